// File: rtl/ro_puf_engine.sv
// ro_puf_engine: ring-oscillator PUF response engine.
// Each enabled RO input has its own 3-flop synchroniser. For every challenge
// pair the engine counts synchronised rising edges of the two selected ROs
// over a programmable window, then compares the two counts to give one bit.
// The bits are assembled into a RESP_BITS-wide response behind a
// start/busy/done handshake.
// Optional feature macro: RO_PUF_TIE_MASK_EN adds the tie_mask_o output,
// which flags bits whose counts are within TIE_MARGIN or that saturated.
module ro_puf_engine #(
  parameter int unsigned NUM_RO    = 16,
  parameter int unsigned SEL_W     = 4,
  parameter int unsigned CNT_W     = 12,
  parameter int unsigned WIN_W     = 12,
  parameter int unsigned RESP_BITS = 8
`ifdef RO_PUF_TIE_MASK_EN
  ,
  parameter int unsigned TIE_MARGIN = 2
`endif
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_RO-1:0]              ro_in_i,
  input  logic                           start_i,
  input  logic [RESP_BITS*2*SEL_W-1:0]   challenge_i,
  input  logic [WIN_W-1:0]               window_i,
  output logic                           ro_enable_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [RESP_BITS-1:0]           response_o,
  output logic [CNT_W-1:0]               cnt_a_o,
  output logic [CNT_W-1:0]               cnt_b_o,
  output logic                           sat_o
`ifdef RO_PUF_TIE_MASK_EN
  ,
  output logic [RESP_BITS-1:0]           tie_mask_o
`endif
);

  localparam int unsigned PAIR_W = 2 * SEL_W;
  localparam int unsigned CHAL_W = RESP_BITS * PAIR_W;
  localparam int unsigned IDX_W  = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_FLUSH,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t                state_q;

  // Synchroniser stages and rising-edge strobes
  logic [NUM_RO-1:0]     sync1_q, sync2_q, sync3_q;
  logic [NUM_RO-1:0]     edge_v;

  // Run context latched at start
  logic [CHAL_W-1:0]     chal_q;
  logic [WIN_W-1:0]      win_q;
  logic [IDX_W-1:0]      idx_q;
  logic [PAIR_W-1:0]     pair_sel;

  // Per-pair working state
  logic [SEL_W-1:0]      sel_a_q, sel_b_q;
  logic [WIN_W-1:0]      run_q;
  logic [1:0]            flush_q;
  logic [CNT_W-1:0]      cnt_a_q, cnt_b_q;
  logic [CNT_W-1:0]      cnt_a_d, cnt_b_d;
  logic                  edge_a, edge_b;
  logic                  hit_a, hit_b;

  // Registered outputs
  logic                  ro_en_q;
  logic                  busy_q;
  logic                  done_q;
  logic [RESP_BITS-1:0]  response_q;
  logic [CNT_W-1:0]      cnt_a_out_q, cnt_b_out_q;
  logic                  sat_q;

`ifdef RO_PUF_TIE_MASK_EN
  logic                  pair_sat_q;
  logic [RESP_BITS-1:0]  tie_q;
  logic [CNT_W-1:0]      diff;
  logic                  tie_hit;
`endif

  // Three-flop synchroniser on every RO input
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= ro_in_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign edge_v   = sync2_q & ~sync3_q;
  assign pair_sel = chal_q[idx_q*PAIR_W +: PAIR_W];

  // Select both strobes from the same synchronised vector; out-of-range selects read 0
  always_comb begin
    edge_a = 1'b0;
    edge_b = 1'b0;
    for (int unsigned i = 0; i < NUM_RO; i++) begin
      if (32'(sel_a_q) == i) edge_a = edge_v[i];
      if (32'(sel_b_q) == i) edge_b = edge_v[i];
    end
  end

  // Saturating next-count for both counters
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    hit_a   = 1'b0;
    hit_b   = 1'b0;
    if (edge_a) begin
      if (cnt_a_q == '1) hit_a = 1'b1;
      else               cnt_a_d = cnt_a_q + CNT_W'(1);
    end
    if (edge_b) begin
      if (cnt_b_q == '1) hit_b = 1'b1;
      else               cnt_b_d = cnt_b_q + CNT_W'(1);
    end
  end

`ifdef RO_PUF_TIE_MASK_EN
  // Absolute count difference against the unreliability margin
  always_comb begin
    diff    = (cnt_a_q > cnt_b_q) ? (cnt_a_q - cnt_b_q) : (cnt_b_q - cnt_a_q);
    tie_hit = (32'(diff) <= TIE_MARGIN) || pair_sat_q;
  end
`endif

  // Response FSM: per-pair CLEAR/RUN/FLUSH/COMPARE, then DONE
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      chal_q      <= '0;
      win_q       <= '0;
      idx_q       <= '0;
      sel_a_q     <= '0;
      sel_b_q     <= '0;
      run_q       <= '0;
      flush_q     <= '0;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
      ro_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      response_q  <= '0;
      cnt_a_out_q <= '0;
      cnt_b_out_q <= '0;
      sat_q       <= 1'b0;
`ifdef RO_PUF_TIE_MASK_EN
      pair_sat_q  <= 1'b0;
      tie_q       <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            chal_q     <= challenge_i;
            win_q      <= window_i;
            idx_q      <= '0;
            busy_q     <= 1'b1;
            sat_q      <= 1'b0;
            response_q <= '0;
`ifdef RO_PUF_TIE_MASK_EN
            tie_q      <= '0;
`endif
            state_q    <= S_CLEAR;
          end
        end

        S_CLEAR: begin
          cnt_a_q <= '0;
          cnt_b_q <= '0;
          sel_a_q <= pair_sel[SEL_W-1:0];
          sel_b_q <= pair_sel[PAIR_W-1:SEL_W];
`ifdef RO_PUF_TIE_MASK_EN
          pair_sat_q <= 1'b0;
`endif
          if (win_q == '0) begin
            flush_q <= 2'd2;
            state_q <= S_FLUSH;
          end else begin
            run_q   <= win_q - WIN_W'(1);
            ro_en_q <= 1'b1;
            state_q <= S_RUN;
          end
        end

        S_RUN: begin
          cnt_a_q <= cnt_a_d;
          cnt_b_q <= cnt_b_d;
          if (hit_a || hit_b) begin
            sat_q <= 1'b1;
`ifdef RO_PUF_TIE_MASK_EN
            pair_sat_q <= 1'b1;
`endif
          end
          if (run_q == '0) begin
            ro_en_q <= 1'b0;
            flush_q <= 2'd2;
            state_q <= S_FLUSH;
          end else begin
            run_q <= run_q - WIN_W'(1);
          end
        end

        S_FLUSH: begin
          cnt_a_q <= cnt_a_d;
          cnt_b_q <= cnt_b_d;
          if (hit_a || hit_b) begin
            sat_q <= 1'b1;
`ifdef RO_PUF_TIE_MASK_EN
            pair_sat_q <= 1'b1;
`endif
          end
          if (flush_q == 2'd0) state_q <= S_COMPARE;
          else                 flush_q <= flush_q - 2'd1;
        end

        S_COMPARE: begin
          response_q[idx_q] <= (cnt_a_q > cnt_b_q);
          cnt_a_out_q       <= cnt_a_q;
          cnt_b_out_q       <= cnt_b_q;
`ifdef RO_PUF_TIE_MASK_EN
          tie_q[idx_q]      <= tie_hit;
`endif
          if (idx_q == IDX_W'(RESP_BITS - 1)) begin
            state_q <= S_DONE;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            state_q <= S_CLEAR;
          end
        end

        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ro_enable_o = ro_en_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign response_o  = response_q;
  assign cnt_a_o     = cnt_a_out_q;
  assign cnt_b_o     = cnt_b_out_q;
  assign sat_o       = sat_q;
`ifdef RO_PUF_TIE_MASK_EN
  assign tie_mask_o  = tie_q;
`endif

endmodule

// File: tb/tb_ro_puf_engine.sv
// Directed bench for ro_puf_engine: a 2-pair main instance and a 1-pair
// instance with 4-bit counters for saturation. RO stimulus is a fixed set of
// square waves gated by each instance's ro_enable, as the RO array would be.
module tb_ro_puf_engine;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // Main instance: RESP_BITS=2, CNT_W=12
  logic [15:0] ro_m;
  logic        start_m;
  logic [15:0] chal_m;
  logic [11:0] win_m;
  logic        en_m, busy_m, done_m, sat_m;
  logic [1:0]  resp_m;
  logic [11:0] ca_m, cb_m;
`ifdef RO_PUF_TIE_MASK_EN
  logic [1:0]  tie_m;
`endif

  // Saturation instance: RESP_BITS=1, CNT_W=4
  logic [15:0] ro_s;
  logic        start_s;
  logic [7:0]  chal_s;
  logic [11:0] win_s;
  logic        en_s, busy_s, done_s, sat_s;
  logic [0:0]  resp_s;
  logic [3:0]  ca_s, cb_s;
`ifdef RO_PUF_TIE_MASK_EN
  logic [0:0]  tie_s;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc   = 0;
  logic [15:0] pat;

  ro_puf_engine #(.NUM_RO(16), .SEL_W(4), .CNT_W(12), .WIN_W(12), .RESP_BITS(2)) u_main (
    .clk_i(clk), .rst_i(rst), .ro_in_i(ro_m), .start_i(start_m),
    .challenge_i(chal_m), .window_i(win_m), .ro_enable_o(en_m), .busy_o(busy_m),
    .done_o(done_m), .response_o(resp_m), .cnt_a_o(ca_m), .cnt_b_o(cb_m), .sat_o(sat_m)
`ifdef RO_PUF_TIE_MASK_EN
    , .tie_mask_o(tie_m)
`endif
  );

  ro_puf_engine #(.NUM_RO(16), .SEL_W(4), .CNT_W(4), .WIN_W(12), .RESP_BITS(1)) u_sat (
    .clk_i(clk), .rst_i(rst), .ro_in_i(ro_s), .start_i(start_s),
    .challenge_i(chal_s), .window_i(win_s), .ro_enable_o(en_s), .busy_o(busy_s),
    .done_o(done_s), .response_o(resp_s), .cnt_a_o(ca_s), .cnt_b_o(cb_s), .sat_o(sat_s)
`ifdef RO_PUF_TIE_MASK_EN
    , .tie_mask_o(tie_s)
`endif
  );

  // RO waves: ro0 period 4, ro3 period 8, ro5 period 16, ro7 period 10; ro1 idle
  always @(negedge clk) begin
    cyc    = cyc + 1;
    pat    = '0;
    pat[0] = cyc[1];
    pat[3] = cyc[2];
    pat[5] = cyc[3];
    pat[7] = ((cyc % 10) >= 5);
    ro_m   = pat & {16{en_m}};
    ro_s   = pat & {16{en_s}};
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a main run; report done edge (edges after the accept edge), pulse
  // count, whether ro_enable was seen high and busy on the first edge.
  // inject_at > 0 pulses start with a different challenge while busy.
  task automatic run_main(input logic [15:0] chal, input logic [11:0] win, input int inject_at,
                          output int done_at, output int done_cnt, output logic en_seen,
                          output logic busy1);
    @(negedge clk);
    chal_m  = chal;
    win_m   = win;
    start_m = 1'b1;
    @(posedge clk);
    #1 start_m = 1'b0;
    done_at  = -1;
    done_cnt = 0;
    en_seen  = 1'b0;
    busy1    = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) busy1 = busy_m;
      if (done_m) begin
        if (done_at < 0) done_at = k;
        done_cnt++;
      end
      if (en_m) en_seen = 1'b1;
      if (inject_at > 0 && k == inject_at) begin
        start_m = 1'b1;
        chal_m  = ~chal;
        win_m   = 12'd0;
      end
      if (inject_at > 0 && k == inject_at + 1) start_m = 1'b0;
      if (done_at >= 0 && k >= done_at + 20) break;
    end
  endtask

  int   d_at, d_cnt;
  logic en_seen, busy1;

  initial begin
    rst = 1'b1; start_m = 1'b0; chal_m = '0; win_m = '0;
    start_s = 1'b0; chal_s = '0; win_s = '0;
    ro_m = '0; ro_s = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", {31'b0, busy_m}, 32'd0);
    check_eq("rst_done", {31'b0, done_m}, 32'd0);
    check_eq("rst_en",   {31'b0, en_m},   32'd0);
    check_eq("rst_resp", {30'b0, resp_m}, 32'd0);
    check_eq("rst_cnt",  {8'b0, ca_m, cb_m}, 32'd0);
    check_eq("rst_sat",  {31'b0, sat_m},  32'd0);
    @(negedge clk) rst = 1'b0;

    // Pairs (3,5),(5,3), window 100
    run_main(16'h3553, 12'd100, 0, d_at, d_cnt, en_seen, busy1);
    check_eq("t1_busy1",   {31'b0, busy1}, 32'd1);
    check_eq("t1_resp",    {30'b0, resp_m}, 32'd1);
    check_eq("t1_done_at", d_at, 32'd211);
    check_eq("t1_done_n",  d_cnt, 32'd1);
    check_eq("t1_cnt_a_6_7",   {31'b0, (ca_m >= 12'd6  && ca_m <= 12'd7)},  32'd1);
    check_eq("t1_cnt_b_12_13", {31'b0, (cb_m >= 12'd12 && cb_m <= 12'd13)}, 32'd1);
    check_eq("t1_sat",     {31'b0, sat_m}, 32'd0);
    check_eq("t1_en_seen", {31'b0, en_seen}, 32'd1);
    check_eq("t1_busy_end",{31'b0, busy_m}, 32'd0);
`ifdef RO_PUF_TIE_MASK_EN
    check_eq("t1_tie", {30'b0, tie_m}, 32'd0);
`endif

    // Pairs (7,7),(7,7), window 50
    run_main(16'h7777, 12'd50, 0, d_at, d_cnt, en_seen, busy1);
    check_eq("t2_resp",    {30'b0, resp_m}, 32'd0);
    check_eq("t2_done_at", d_at, 32'd111);
    check_eq("t2_cnt_eq",  {20'b0, ca_m ^ cb_m}, 32'd0);
    check_eq("t2_cnt_5_6", {31'b0, (ca_m >= 12'd5 && ca_m <= 12'd6)}, 32'd1);
`ifdef RO_PUF_TIE_MASK_EN
    check_eq("t2_tie", {30'b0, tie_m}, 32'd3);
`endif

    // Window 0
    run_main(16'h3553, 12'd0, 0, d_at, d_cnt, en_seen, busy1);
    check_eq("t3_resp",    {30'b0, resp_m}, 32'd0);
    check_eq("t3_cnt",     {8'b0, ca_m, cb_m}, 32'd0);
    check_eq("t3_done_at", d_at, 32'd11);
    check_eq("t3_en_seen", {31'b0, en_seen}, 32'd0);
`ifdef RO_PUF_TIE_MASK_EN
    check_eq("t3_tie", {30'b0, tie_m}, 32'd3);
`endif

    // Saturation: CNT_W=4, pair (0,1), window 200
    @(negedge clk);
    chal_s = 8'h10; win_s = 12'd200; start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    d_at = -1;
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clk);
      #1;
      if (done_s) begin
        d_at = k;
        break;
      end
    end
    check_eq("t4_done_at", d_at, 32'd206);
    check_eq("t4_cnt_a",   {28'b0, ca_s}, 32'd15);
    check_eq("t4_cnt_b",   {28'b0, cb_s}, 32'd0);
    check_eq("t4_sat",     {31'b0, sat_s}, 32'd1);
    check_eq("t4_resp",    {31'b0, resp_s}, 32'd1);
`ifdef RO_PUF_TIE_MASK_EN
    check_eq("t4_tie", {31'b0, tie_s}, 32'd1);
`endif

    // Reset during RUN of pair 1, then a normal run
    @(negedge clk);
    chal_m = 16'h3553; win_m = 12'd100; start_m = 1'b1;
    @(posedge clk);
    #1 start_m = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    check_eq("t5_pre_en",   {31'b0, en_m}, 32'd1);
    check_eq("t5_pre_resp", {30'b0, resp_m}, 32'd1);
    @(negedge clk) rst = 1'b1;
    #1;
    check_eq("t5_busy", {31'b0, busy_m}, 32'd0);
    check_eq("t5_en",   {31'b0, en_m},   32'd0);
    check_eq("t5_resp", {30'b0, resp_m}, 32'd0);
    check_eq("t5_cnt",  {8'b0, ca_m, cb_m}, 32'd0);
    @(negedge clk) rst = 1'b0;
    run_main(16'h3553, 12'd100, 0, d_at, d_cnt, en_seen, busy1);
    check_eq("t5_resp2",    {30'b0, resp_m}, 32'd1);
    check_eq("t5_done_at2", d_at, 32'd211);

    // Start pulse and challenge change while busy are ignored
    run_main(16'h3553, 12'd100, 50, d_at, d_cnt, en_seen, busy1);
    check_eq("t6_resp",    {30'b0, resp_m}, 32'd1);
    check_eq("t6_done_at", d_at, 32'd211);
    check_eq("t6_done_n",  d_cnt, 32'd1);
    check_eq("t6_cnt_b_12_13", {31'b0, (cb_m >= 12'd12 && cb_m <= 12'd13)}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
